// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM encoding, default widths and the timeout read code.
// Imported by the initiator, its timeout counter and the slave-side decoder.
package apb_pkg;

   localparam int unsigned APB_DATA_WIDTH = 32;
   localparam int unsigned APB_ADDR_WIDTH = 16;
   localparam logic [31:0] APB_TOUT_CODE  = 32'hDEADDEAD;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   // Width needed to hold 0..max_cyc; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned max_cyc);
      return (max_cyc < 1) ? 1 : $clog2(max_cyc + 1);
   endfunction

endpackage

// File: rtl/apb_mst_if_if.sv
// Command/response channels plus the APB bus driven by the initiator.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
interface apb_mst_if_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 16
);

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;

   logic                  psel_mi;
   logic                  penable_mi;
   logic                  pwrite_mi;
   logic [ADDR_WIDTH-1:0] paddr_mi;
   logic [DATA_WIDTH-1:0] pwdata_mi;
   logic [DATA_WIDTH-1:0] prdata_s;
   logic                  pready_s;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata_s, pready_s,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      output psel_mi, penable_mi, pwrite_mi, paddr_mi, pwdata_mi
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata_s, pready_s,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      input  psel_mi, penable_mi, pwrite_mi, paddr_mi, pwdata_mi
   );

endinterface

// File: rtl/apb_tout_cnt.sv
// Saturating ACCESS-phase wait counter; hit_o flags the cycle whose increment reaches MAX_CYC.
// MAX_CYC = 0 disables hit_o entirely.
module apb_tout_cnt
   import apb_pkg::*;
#(
   parameter int unsigned MAX_CYC = 255
) (
   input  logic clk,
   input  logic rst_b,
   input  logic clr_i,
   input  logic en_i,
   output logic hit_o
);

   localparam int unsigned    W    = cnt_width(MAX_CYC);
   localparam logic [W-1:0]   SAT  = W'(MAX_CYC);
   localparam logic [W-1:0]   LAST = (MAX_CYC == 0) ? '0 : W'(MAX_CYC - 1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_b || clr_i) begin
         cnt_q <= '0;
      end else if (en_i && (cnt_q != SAT)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign hit_o = (MAX_CYC != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/apb_mst_if.sv
// APB initiator: turns one accepted command into a SETUP/ACCESS transfer and returns one response.
// All bus and response outputs come straight from registers.
module apb_mst_if
   import apb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = APB_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH  = APB_ADDR_WIDTH,
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter logic [31:0] TOUT_CODE   = APB_TOUT_CODE
) (
   input  logic         clk,
   input  logic         rst_b,
   apb_mst_if_if.master bus,
   output apb_state_e   state_o
);

   localparam logic [DATA_WIDTH-1:0] TOUT_DATA = DATA_WIDTH'(TOUT_CODE);

   apb_state_e            state_q, state_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic                  cnt_clr, cnt_en, cnt_hit;

   apb_tout_cnt #(
      .MAX_CYC (TIMEOUT_CYC)
   ) u_tout (
      .clk   (clk),
      .rst_b (rst_b),
      .clr_i (cnt_clr),
      .en_i  (cnt_en),
      .hit_o (cnt_hit)
   );

   always_comb begin
      state_d   = state_q;
      psel_d    = 1'b0;
      penable_d = 1'b0;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      cnt_en    = 1'b0;
      cnt_clr   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               pwrite_d = bus.cmd_write;
               paddr_d  = bus.cmd_addr;
               pwdata_d = bus.cmd_wdata;
               psel_d   = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            psel_d    = 1'b1;
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            cnt_en = !bus.pready_s;
            // pready is checked first so a ready slave beats a coincident timeout.
            if (bus.pready_s) begin
               rdata_d = pwrite_q ? '0 : bus.prdata_s;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_hit) begin
               rdata_d = TOUT_DATA;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               psel_d    = 1'b1;
               penable_d = 1'b1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               cnt_clr = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state_q   <= IDLE;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   assign bus.cmd_ready  = (state_q == IDLE);
   assign bus.rsp_valid  = (state_q == RESP);
   assign bus.rsp_rdata  = rdata_q;
   assign bus.rsp_err    = err_q;
   assign bus.psel_mi    = psel_q;
   assign bus.penable_mi = penable_q;
   assign bus.pwrite_mi  = pwrite_q;
   assign bus.paddr_mi   = paddr_q;
   assign bus.pwdata_mi  = pwdata_q;
   assign state_o        = state_q;

endmodule

// File: doc/apb_mst_if.md
Name: apb_mst_if

Overview:
- APB initiator (master interface) that converts a simple valid/ready command channel into APB SETUP/ACCESS transfers.
- Drives the shared paddr/pwdata/pwrite/psel/penable bus toward the slave-side address decoder.
- Collects prdata/pready and returns one response per command on a valid/ready response channel.
- Provides an ACCESS-phase timeout so a stalled slave cannot hang the bus.

Parameters:
DATA_WIDTH, 32, APB data width
ADDR_WIDTH, 16, APB address width
TIMEOUT_CYC, 255, max ACCESS cycles waiting for pready; 0 disables the timeout
TOUT_CODE, 32'hDEADDEAD, read data returned on timeout (truncated to DATA_WIDTH)

Ports:
clk  input  1  system clock; all logic on the rising edge
rst_b  input  1  reset, synchronous, active-low
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_WIDTH  transfer address
cmd_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  output  DATA_WIDTH  read data; 0 for writes; TOUT_CODE on timeout
rsp_err  output  1  1 = transfer timed out
psel_mi  output  1  APB select toward the decoder
penable_mi  output  1  APB enable
pwrite_mi  output  1  APB direction
paddr_mi  output  ADDR_WIDTH  APB address
pwdata_mi  output  DATA_WIDTH  APB write data
prdata_s  input  DATA_WIDTH  read data from the decoder
pready_s  input  1  ready from the decoder

Behaviour:
- Reset: rst_b sampled low at a clk edge puts the FSM in IDLE and zeroes all registered outputs, the timeout counter and the response registers.
  - This applies mid-transfer too: psel_mi and penable_mi are 0 from the first edge with rst_b low.
  - Any in-flight response is discarded; no response is issued for the aborted command.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1 only in IDLE.
  - On accept: cmd_write, cmd_addr and cmd_wdata are registered into pwrite_mi, paddr_mi and pwdata_mi, then go to SETUP.
  - These bus signals stay stable until the FSM leaves ACCESS.
- SETUP (exactly 1 cycle): psel_mi = 1, penable_mi = 0, then go to ACCESS.
- ACCESS: psel_mi = 1, penable_mi = 1; the timeout counter increments every ACCESS cycle in which pready_s = 0.
  - pready_s = 1: capture prdata_s into rsp_rdata for reads (0 for writes), rsp_err = 0, go to RESP.
  - Timeout (TIMEOUT_CYC != 0 and counter == TIMEOUT_CYC with pready_s still 0): rsp_rdata = TOUT_CODE, rsp_err = 1, go to RESP.
  - pready_s = 1 in the same cycle the timeout would fire: pready wins (normal completion).
- RESP:
  - psel_mi = 0, penable_mi = 0, rsp_valid = 1.
  - rsp_rdata and rsp_err are held stable until rsp_ready = 1, then go to IDLE.
  - The counter clears on entry to IDLE.
- No command is accepted in RESP, so the next cmd_ready is 1 the cycle after the handshake. Back-to-back throughput is 1 transfer per 4 cycles with zero-wait slaves and rsp_ready held high.
- Latency with a zero-wait slave: accept at edge N; SETUP in cycle N+1; ACCESS in N+2 (pready sampled); rsp_valid high in N+3.
- psel_mi and penable_mi are never high outside SETUP/ACCESS; penable_mi is never high without psel_mi.
- Outputs are registered, not combinational from pready_s.
- The timeout counter is clog2(TIMEOUT_CYC+1) bits wide, with a minimum of 1 bit, and saturates.
- cmd_* inputs are ignored outside IDLE.

Decomposition:
- Shared package apb_pkg:
  - FSM state enum (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3).
  - TOUT_CODE default.
  - Default DATA_WIDTH/ADDR_WIDTH constants, shared with the decoder.
- Optional sub-module apb_tout_cnt: saturating counter with clear/enable/hit outputs. Everything else stays flat in apb_mst_if.

Test Plan:
- Read, zero-wait: cmd read addr 16'h4010, slave returns prdata 32'h12345678 with pready=1 → psel_mi high 2 cycles, penable_mi high 1 cycle; rsp_valid 3 cycles after accept with rdata 32'h12345678, err 0.
- Write, 3 wait states: cmd write addr 16'h0004 data 32'hA5A5A5A5, pready low 3 ACCESS cycles → ACCESS lasts 4 cycles; paddr/pwdata stable throughout; rsp_rdata 0, err 0.
- Timeout: TIMEOUT_CYC=8, pready held 0 → psel/penable drop after 8 ACCESS cycles; rsp_err 1, rsp_rdata 32'hDEADDEAD; a following normal read completes correctly.
- Backpressure: rsp_ready held 0 for 5 cycles → rsp_valid and data stable; cmd_ready stays 0; psel_mi 0; acceptance resumes the cycle after the rsp handshake.
- Reset mid-ACCESS: rst_b low during ACCESS → psel/penable/rsp_valid are 0 at the next edge; cmd_ready 1 after release; no stale response appears.
- Pready coincident with timeout: TIMEOUT_CYC=4, pready=1 on the 4th ACCESS cycle with prdata 32'h0000BEEF → err 0, rdata 32'h0000BEEF.
